// File: rtl/parking_sensor_gen_pkg.sv
// parking_sensor_gen_pkg: shared state, direction and sensor-level constants
package parking_sensor_gen_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    GAP  = 3'd4
  } state_t;
  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_00 = 2'b00;
  // exit plays the enter sequence mirrored; PH2 and idle/gap are direction-free
  function automatic logic [1:0] ab_of(input state_t s, input logic dir);
    return s == PH1 ? (dir == DIR_EXIT ? AB_01 : AB_10) :
           s == PH2 ? AB_11 :
           s == PH3 ? (dir == DIR_EXIT ? AB_10 : AB_01) : AB_00;
  endfunction
endpackage

// File: rtl/parking_sensor_gen_if.sv
// parking_sensor_gen_if: request handshake and sensor outputs of the generator
interface parking_sensor_gen_if;
  logic req_valid;
  logic req_dir;
  logic req_ready;
  logic a;
  logic b;
  logic busy;
  logic done;
  logic dir_o;
  modport master (output req_valid, req_dir, input req_ready, a, b, busy, done, dir_o);
  modport slave  (input req_valid, req_dir, output req_ready, a, b, busy, done, dir_o);
endinterface

// File: rtl/parking_sensor_gen_dwell_timer.sv
// parking_sensor_gen_dwell_timer: wrapping 0..DWELL-1 counter marking phase ends
module parking_sensor_gen_dwell_timer #(
  parameter int DWELL = 5000000,
  parameter int CNT_W = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  logic [CNT_W-1:0] r_count;
  assign o_expire = r_count == CNT_W'(DWELL - 1);
  // count while enabled, wrap at the last dwell cycle, clear on a new sequence
  always_ff @(posedge clk) begin
    if (reset || i_clear || (i_enable && o_expire)) r_count <= '0;
    else if (i_enable) r_count <= r_count + 1'b1;
  end
endmodule

// File: rtl/parking_sensor_gen.sv
// parking_sensor_gen: plays one four-phase a/b car sequence per accepted request
module parking_sensor_gen
  import parking_sensor_gen_pkg::*;
#(
  parameter int DWELL = 5000000,
  parameter int CNT_W = 24
) (
  input  logic clk,
  input  logic reset,
  parking_sensor_gen_if.slave bus
);
  state_t     r_state, w_next;
  logic [1:0] r_ab;
  logic       r_ready, r_busy, r_done, r_dir;
  logic       w_accept, w_expire, w_dir;
  assign w_accept = r_state == IDLE && bus.req_valid;
  assign w_dir    = w_accept ? bus.req_dir : r_dir;
  parking_sensor_gen_dwell_timer #(.DWELL(DWELL), .CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_accept),
    .i_enable (r_state != IDLE),
    .o_expire (w_expire)
  );
  // next state: accept from idle, otherwise step one phase per expired dwell
  always_comb begin
    w_next = r_state;
    w_next = w_accept ? PH1 :
             (r_state == IDLE || !w_expire) ? r_state :
             r_state == PH1 ? PH2 :
             r_state == PH2 ? PH3 :
             r_state == PH3 ? GAP : IDLE;
  end
  // outputs are registered from the next state so levels change with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ab    <= AB_00;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dir   <= DIR_ENTER;
    end else begin
      r_state <= w_next;
      r_ab    <= ab_of(w_next, w_dir);
      r_ready <= w_next == IDLE;
      r_busy  <= w_next != IDLE;
      r_done  <= r_state == GAP && w_next == IDLE;
      r_dir   <= w_dir;
    end
  end
  assign bus.a         = r_ab[1];
  assign bus.b         = r_ab[0];
  assign bus.req_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dir_o     = r_dir;
endmodule

// File: doc/parking_sensor_gen.md
Name: parking_sensor_gen

Overview:
- Generates the two-photo-sensor waveform (a, b) of one car entering or leaving the lot, on request.
- It is the transmitter for the a/b sequence-detector FSM in the parking-meter design.
- It drives that detector in simulation, and on the board through a loopback, in place of the manual switches.
- Each request plays back one complete, legal four-phase sequence with a programmable dwell time per phase.

Parameters:
- DWELL, 5000000: clock cycles each phase is held (100 ms at 50 MHz). Legal range 1..2^24-1; the bench uses 3.
- CNT_W, 24: width of the dwell counter. Must satisfy 2^CNT_W > DWELL.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request for one car sequence
- req_dir  in  1  direction: 0 = enter, 1 = exit; sampled only on accept
- req_ready  out  1  high when a request can be accepted (state IDLE)
- a  out  1  sensor A (outer) level, registered
- b  out  1  sensor B (inner) level, registered
- busy  out  1  sequence in progress (inverse of req_ready)
- done  out  1  one-cycle pulse when a sequence completes
- dir_o  out  1  direction of the current or last sequence

Behaviour:
- One clock, clk. Reset is synchronous and active-high, on port reset. All outputs are registered.
- Reset values: a=0, b=0, req_ready=1, busy=0, done=0, dir_o=0, state=IDLE, counter=0.
- States: IDLE, PH1, PH2, PH3, GAP.
- Accept: at an edge with state==IDLE and req_valid=1. req_dir is latched into dir_o, state goes to PH1, counter is cleared.
- Phase levels (a,b):
  - enter: PH1=10, PH2=11, PH3=01, GAP=00
  - exit: PH1=01, PH2=11, PH3=10, GAP=00
  - IDLE=00
- Latency: the first PH1 level appears the cycle after the accept edge.
- Each of PH1, PH2, PH3 and GAP lasts exactly DWELL cycles.
- The counter counts 0..DWELL-1. The state advances when counter==DWELL-1, and the counter then wraps to 0.
- GAP -> IDLE transition:
  - done=1 for exactly the first IDLE cycle.
  - req_ready returns to 1 in that same cycle.
- Total: accept at edge k; busy is high cycles k+1..k+4*DWELL; done and ready are high at cycle k+4*DWELL+1.
- Back-to-back: a request valid during the done cycle is accepted. The next PH1 starts the following cycle, so at least DWELL cycles of 00 always separate two sequences.
- req_valid while busy: ignored and not queued. The request must be held until req_ready.
- req_dir changes while busy: no effect.
- Only one encoding changes per phase boundary (Gray-like), so no a/b glitch through illegal codes.
- Reset mid-sequence: the next cycle is IDLE with a=b=0 and req_ready=1. No done pulse is issued, and dir_o is cleared.
- DWELL=1: each phase lasts one cycle and the sequence takes 4 cycles; behaviour is otherwise identical.

Decomposition:
- Shared include file holds:
  - state encoding localparams (IDLE, PH1, PH2, PH3, GAP)
  - DIR_ENTER/DIR_EXIT constants
  - phase-to-(a,b) constants: 2'b10, 2'b11, 2'b01, 2'b00
- One sub-module, dwell_timer:
  - loadable counter with parameter DWELL
  - inputs clear and enable; output expire = (count==DWELL-1)
- The top block holds the FSM and the output registers.

Test Plan (DWELL=3; cycle 0 = accept edge):
- Reset held 2 cycles -> a=0, b=0, req_ready=1, busy=0, done=0, dir_o=0.
- Enter, req_valid=1/req_dir=0 at cycle 0:
  - ab=10 on cycles 1-3, 11 on 4-6, 01 on 7-9, 00 on 10-12
  - done=1 and req_ready=1 only on cycle 13; busy=1 on cycles 1-12
- Exit, req_dir=1 -> ab=01, 11, 10, 00 in the same windows; dir_o=1 from cycle 1.
- req_valid pulsed on cycle 5 with req_dir flipped -> ignored; waveform and done timing identical to the plain enter case.
- req_valid held high continuously -> second sequence PH1 starts at cycle 14 (ab=10); done pulses on cycles 13 and 26.
- reset asserted on cycle 6 (state PH2) -> cycle 7: ab=00, req_ready=1, dir_o=0; no done pulse; a new request at cycle 8 starts a clean sequence.
